// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory load/store initiator.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B     = 2'd0,
    SIZE_H     = 2'd1,
    SIZE_W     = 2'd2,
    SIZE_W_ALT = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_e;

  // Mask bit order is {mask_3, mask_2, mask_1, mask_0}
  localparam logic [3:0] MASK_B = 4'b1000;
  localparam logic [3:0] MASK_H = 4'b1100;
  localparam logic [3:0] MASK_W = 4'b1111;

  function automatic int rd_cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return MASK_B;
      SIZE_H:  return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_extend.sv
// Combinational load extender: picks the low byte/half/word of the read data
// and sign- or zero-extends it to the full data width.
module mem_lsu_extend
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = data;
    case (size)
      SIZE_B:  result = {{(DATA_WIDTH-8){data[7] & ~is_unsigned}}, data[7:0]};
      SIZE_H:  result = {{(DATA_WIDTH-16){data[15] & ~is_unsigned}}, data[15:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/mem_data_lsu.sv
// Load/store initiator for the data port of the dual-port memory model.
// Optional MEM_MISALIGN_CHECK_EN: reject misaligned half/word accesses with oRespErr.
module mem_data_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  iClock,
  input  logic                  iResetN,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic                  iReqWen,
  input  logic [1:0]            iReqSize,
  input  logic                  iReqUnsigned,
  input  logic [ADDR_WIDTH-1:0] iReqAddr,
  input  logic [DATA_WIDTH-1:0] iReqData,
  output logic                  oRespValid,
  input  logic                  iRespReady,
  output logic [DATA_WIDTH-1:0] oRespData,
  output logic                  oRespErr,
  output logic                  pMemData_pRd_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr,
  input  logic [DATA_WIDTH-1:0] pMemData_pRd_bData,
  output logic                  pMemData_pWr_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr,
  output logic [DATA_WIDTH-1:0] pMemData_pWr_bData,
  output logic                  pMemData_pWr_bMask_0,
  output logic                  pMemData_pWr_bMask_1,
  output logic                  pMemData_pWr_bMask_2,
  output logic                  pMemData_pWr_bMask_3
);

  localparam int              CNT_W   = rd_cnt_width(RD_LATENCY);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(RD_LATENCY);

  lsu_state_e            state, state_next;
  logic                  run_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [3:0]            wr_mask;
  logic                  accept;
  logic                  misaligned;
  logic                  rd_done;

`ifdef MEM_MISALIGN_CHECK_EN
  logic err_q;

  assign misaligned = (iReqSize == SIZE_B) ? 1'b0 :
                      (iReqSize == SIZE_H) ? iReqAddr[0] : (|iReqAddr[1:0]);

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN)    err_q <= 1'b0;
    else if (accept) err_q <= misaligned;
  end

  assign oRespErr = oRespValid & err_q;
`else
  assign misaligned = 1'b0;
  assign oRespErr   = 1'b0;
`endif

  // run_q keeps oReqReady low while reset is asserted and for the first cycle after
  assign accept  = (state == ST_IDLE) && run_q && iReqValid;
  assign rd_done = (state == ST_RD_WAIT) && (cnt_q == LAT_CNT);

  mem_lsu_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
    .data        (pMemData_pRd_bData),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .result      (load_ext)
  );

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state <= ST_IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_next;
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      addr_q      <= '0;
      data_q      <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q      <= iReqAddr;
        data_q      <= iReqData;
        size_q      <= iReqSize;
        unsigned_q  <= iReqUnsigned;
        resp_data_q <= '0;
      end
      if (state == ST_RD_ISSUE) cnt_q <= CNT_W'(1);
      if (state == ST_RD_WAIT) begin
        if (rd_done) resp_data_q <= load_ext;
        else         cnt_q       <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next       = state;
    oReqReady        = 1'b0;
    oRespValid       = 1'b0;
    oRespData        = '0;
    pMemData_pRd_bEn = 1'b0;
    pMemData_pWr_bEn = 1'b0;
    wr_mask          = 4'b0000;
    case (state)
      ST_IDLE: begin
        oReqReady = run_q;
        if (accept) begin
          if (misaligned)   state_next = ST_RESP;
          else if (iReqWen) state_next = ST_WR_ISSUE;
          else              state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        pMemData_pRd_bEn = 1'b1;
        state_next       = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_done) state_next = ST_RESP;
      end
      ST_WR_ISSUE: begin
        pMemData_pWr_bEn = 1'b1;
        wr_mask          = size_mask(size_q);
        state_next       = ST_RESP;
      end
      ST_RESP: begin
        oRespValid = 1'b1;
        oRespData  = resp_data_q;
        if (iRespReady) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pMemData_pRd_bAddr   = addr_q;
  assign pMemData_pWr_bAddr   = addr_q;
  assign pMemData_pWr_bData   = data_q;
  assign pMemData_pWr_bMask_0 = wr_mask[0];
  assign pMemData_pWr_bMask_1 = wr_mask[1];
  assign pMemData_pWr_bMask_2 = wr_mask[2];
  assign pMemData_pWr_bMask_3 = wr_mask[3];

endmodule

// File: tb/tb_mem_data_lsu.sv
// Self-checking bench for mem_data_lsu: vector table with a response scoreboard,
// plus backpressure and mid-read reset sequences.
module tb_mem_data_lsu;
  import mem_pkg::*;

  logic        iClock = 1'b0;
  logic        iResetN = 1'b0;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic        iReqWen = 1'b0;
  logic [1:0]  iReqSize = 2'd0;
  logic        iReqUnsigned = 1'b0;
  logic [31:0] iReqAddr = '0;
  logic [31:0] iReqData = '0;
  logic        oRespValid;
  logic        iRespReady = 1'b1;
  logic [31:0] oRespData;
  logic        oRespErr;
  logic        pRdEn, pWrEn, m0, m1, m2, m3;
  logic [31:0] pRdAddr, pWrAddr, pWrData;
  logic [31:0] pRdData = '0;
  logic [31:0] mem_rdata = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_mask;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb_q[$];

  mem_data_lsu dut (
    .iClock               (iClock),
    .iResetN              (iResetN),
    .iReqValid            (iReqValid),
    .oReqReady            (oReqReady),
    .iReqWen              (iReqWen),
    .iReqSize             (iReqSize),
    .iReqUnsigned         (iReqUnsigned),
    .iReqAddr             (iReqAddr),
    .iReqData             (iReqData),
    .oRespValid           (oRespValid),
    .iRespReady           (iRespReady),
    .oRespData            (oRespData),
    .oRespErr             (oRespErr),
    .pMemData_pRd_bEn     (pRdEn),
    .pMemData_pRd_bAddr   (pRdAddr),
    .pMemData_pRd_bData   (pRdData),
    .pMemData_pWr_bEn     (pWrEn),
    .pMemData_pWr_bAddr   (pWrAddr),
    .pMemData_pWr_bData   (pWrData),
    .pMemData_pWr_bMask_0 (m0),
    .pMemData_pWr_bMask_1 (m1),
    .pMemData_pWr_bMask_2 (m2),
    .pMemData_pWr_bMask_3 (m3)
  );

  always #5 iClock = ~iClock;

  always @(posedge iClock) cyc <= cyc + 1;

  // Memory model with one cycle of read latency
  always @(posedge iClock) if (pRdEn) pRdData <= mem_rdata;

  function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mdata, input logic [31:0] exp_data,
                              input logic exp_err, input logic [3:0] mask,
                              input int lat, input int rd, input int wr);
    vec_t v;
    v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.mdata = mdata; v.exp_data = exp_data; v.exp_err = exp_err; v.exp_mask = mask;
    v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, output int t_acc);
    @(negedge iClock);
    check_output("req_ready_idle", {31'd0, oReqReady}, 32'd1);
    iReqValid    = 1'b1;
    iReqWen      = v.wen;
    iReqSize     = v.size;
    iReqUnsigned = v.uns;
    iReqAddr     = v.addr;
    iReqData     = v.wdata;
    mem_rdata    = v.mdata;
    t_acc        = cyc;
    sb_q.push_back('{data: v.exp_data, err: v.exp_err});
    @(negedge iClock);
    iReqValid = 1'b0;
  endtask

  // Watch the memory port until a response appears, then score it
  task automatic wait_response(input vec_t v, input int t_acc);
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          rd_cyc = -1;
    int          wr_cyc = -1;
    logic [31:0] rd_addr = '0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  mask_seen = '0;
    bit          got = 0;
    resp_t       exp;
    for (int i = 0; i < 20; i++) begin
      if (pRdEn) begin rd_cnt++; rd_cyc = cyc - t_acc; rd_addr = pRdAddr; end
      if (pWrEn) begin
        wr_cnt++; wr_cyc = cyc - t_acc; wr_addr = pWrAddr; wr_data = pWrData;
        mask_seen = {m3, m2, m1, m0};
      end
      if (oRespValid) begin got = 1; break; end
      @(negedge iClock);
    end
    if (!got) begin
      check_output("resp_timeout", 32'd0, 32'd1);
      return;
    end
    check_output("resp_latency", cyc - t_acc, v.exp_lat);
    if (sb_q.size() == 0) begin
      check_output("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check_output("resp_data", oRespData, exp.data);
      check_output("resp_err", {31'd0, oRespErr}, {31'd0, exp.err});
    end
    check_output("rd_en_count", rd_cnt, v.exp_rd);
    check_output("wr_en_count", wr_cnt, v.exp_wr);
    if (v.exp_rd != 0) begin
      check_output("rd_en_cycle", rd_cyc, 32'd1);
      check_output("rd_addr", rd_addr, v.addr);
    end
    if (v.exp_wr != 0) begin
      check_output("wr_en_cycle", wr_cyc, 32'd1);
      check_output("wr_addr", wr_addr, v.addr);
      check_output("wr_data", wr_data, v.wdata);
      check_output("wr_mask", {28'd0, mask_seen}, {28'd0, v.exp_mask});
    end
    @(negedge iClock);
    check_output("resp_dropped", {31'd0, oRespValid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ctrl"}, {24'd0, oReqReady, oRespValid, oRespErr, pRdEn, pWrEn, m3, m2, m1},
                 32'd0);
    check_output({tag, "_m0"}, {31'd0, m0}, 32'd0);
    check_output({tag, "_resp_data"}, oRespData, 32'd0);
    check_output({tag, "_rd_addr"}, pRdAddr, 32'd0);
    check_output({tag, "_wr_addr"}, pWrAddr, 32'd0);
    check_output({tag, "_wr_data"}, pWrData, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int    t_acc;
    vec_t  v;
    resp_t held;
    logic [31:0] held_data;
    bit    seen;

    vecs.push_back(mk(0, SIZE_W, 0, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(0, SIZE_B, 0, 32'h8000_0004, 32'h0, 32'h0000_00F0, 32'hFFFF_FFF0, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(0, SIZE_B, 1, 32'h8000_0004, 32'h0, 32'h0000_00F0, 32'h0000_00F0, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(0, SIZE_H, 0, 32'h8000_0000, 32'h0, 32'h0000_8001, 32'hFFFF_8001, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(0, SIZE_H, 1, 32'h8000_0010, 32'h0, 32'h1234_8001, 32'h0000_8001, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(0, SIZE_B, 0, 32'h8000_0014, 32'h0, 32'h1234_567F, 32'h0000_007F, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(0, SIZE_B, 1, 32'h8000_0018, 32'h0, 32'hFFFF_FF80, 32'h0000_0080, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(0, 2'd3,   0, 32'h8000_001C, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(1, SIZE_H, 0, 32'h8000_0008, 32'h1234_ABCD, 32'h0, 32'h0, 0, 4'b1100, 2, 0, 1));
    vecs.push_back(mk(1, SIZE_B, 0, 32'h8000_000C, 32'h0000_00AA, 32'h0, 32'h0, 0, 4'b1000, 2, 0, 1));
    vecs.push_back(mk(1, SIZE_W, 0, 32'h8000_0020, 32'h5555_AAAA, 32'h0, 32'h0, 0, 4'b1111, 2, 0, 1));
`ifdef MEM_MISALIGN_CHECK_EN
    vecs.push_back(mk(0, SIZE_W, 0, 32'h8000_0002, 32'h0, 32'h1111_2222, 32'h0, 1, 4'b0000, 1, 0, 0));
    vecs.push_back(mk(1, SIZE_H, 0, 32'h8000_0009, 32'h0000_BEEF, 32'h0, 32'h0, 1, 4'b0000, 1, 0, 0));
`else
    vecs.push_back(mk(0, SIZE_W, 0, 32'h8000_0002, 32'h0, 32'h1111_2222, 32'h1111_2222, 0, 4'b0000, 3, 1, 0));
    vecs.push_back(mk(1, SIZE_H, 0, 32'h8000_0009, 32'h0000_BEEF, 32'h0, 32'h0, 0, 4'b1100, 2, 0, 1));
`endif

    #3;
    check_all_zero("reset");
    @(negedge iClock);
    @(negedge iClock);
    iResetN = 1'b1;
    @(negedge iClock);
    @(negedge iClock);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], t_acc);
      wait_response(vecs[i], t_acc);
    end

    // Response backpressure: output must hold and nothing new may start
    $display("[TB] backpressure sequence");
    iRespReady = 1'b0;
    v = mk(0, SIZE_W, 0, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 4'b0000, 3, 1, 0);
    apply_stimulus(v, t_acc);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (oRespValid) begin seen = 1; break; end
      @(negedge iClock);
    end
    check_output("bp_resp_seen", {31'd0, seen}, 32'd1);
    check_output("bp_latency", cyc - t_acc, 32'd3);
    held_data = oRespData;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClock);
      check_output("bp_valid_held", {31'd0, oRespValid}, 32'd1);
      check_output("bp_data_held", oRespData, 32'h0BAD_F00D);
      check_output("bp_ready_low", {31'd0, oReqReady}, 32'd0);
      check_output("bp_no_enable", {30'd0, pRdEn, pWrEn}, 32'd0);
    end
    if (sb_q.size() != 0) begin
      held = sb_q.pop_front();
      check_output("bp_data_first", held_data, held.data);
    end else begin
      check_output("bp_scoreboard_empty", 32'd0, 32'd1);
    end
    iRespReady = 1'b1;
    @(negedge iClock);
    check_output("bp_release_valid", {31'd0, oRespValid}, 32'd0);
    check_output("bp_release_ready", {31'd0, oReqReady}, 32'd1);

    // Reset asserted while the read is waiting for memory data
    $display("[TB] reset during read wait");
    v = mk(0, SIZE_W, 0, 32'h8000_0080, 32'h0, 32'h7777_8888, 32'h7777_8888, 0, 4'b0000, 3, 1, 0);
    apply_stimulus(v, t_acc);
    void'(sb_q.pop_back());
    @(posedge iClock);
    #2;
    iResetN = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge iClock);
    @(negedge iClock);
    check_all_zero("held_reset");
    iResetN = 1'b1;
    @(negedge iClock);
    @(negedge iClock);
    v = mk(0, SIZE_W, 0, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 4'b0000, 3, 1, 0);
    apply_stimulus(v, t_acc);
    wait_response(v, t_acc);

    check_output("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
